// File: rtl/ibex_rvfi_replay_pkg.sv
// rtl/ibex_rvfi_replay_pkg.sv - record type, word/header layout constants and header decode for the RVFI trace replay source
//
// Contents:
//   rvfi_rec_t          one complete retirement record as carried through the FIFO
//   RecWords, RecMagic  record framing constants
//   Hdr*                bit offsets of the fields inside the header word
//   hdr_decode()        fills the header-derived fields of a record from a header word
package ibex_rvfi_replay_pkg;

    localparam int unsigned RecWords = 10;
    localparam logic [3:0]  RecMagic = 4'hA;

    // Header word layout
    localparam int unsigned HdrMagicLsb = 28;
    localparam int unsigned HdrTrapBit  = 27;
    localparam int unsigned HdrHaltBit  = 26;
    localparam int unsigned HdrIntrBit  = 25;
    localparam int unsigned HdrModeLsb  = 23;
    localparam int unsigned HdrRdLsb    = 18;
    localparam int unsigned HdrRs1Lsb   = 13;
    localparam int unsigned HdrRs2Lsb   = 8;
    localparam int unsigned HdrRmaskLsb = 4;
    localparam int unsigned HdrWmaskLsb = 0;

    typedef struct packed {
        logic        trap;
        logic        halt;
        logic        intr;
        logic [1:0]  mode;
        logic [4:0]  rd_addr;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] insn;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_rec_t;

    // Returns rec with only the header-derived fields replaced.
    function automatic rvfi_rec_t hdr_decode(rvfi_rec_t rec, logic [31:0] hdr);
        rvfi_rec_t r;
        r           = rec;
        r.trap      = hdr[HdrTrapBit];
        r.halt      = hdr[HdrHaltBit];
        r.intr      = hdr[HdrIntrBit];
        r.mode      = hdr[HdrModeLsb  +: 2];
        r.rd_addr   = hdr[HdrRdLsb    +: 5];
        r.rs1_addr  = hdr[HdrRs1Lsb   +: 5];
        r.rs2_addr  = hdr[HdrRs2Lsb   +: 5];
        r.mem_rmask = hdr[HdrRmaskLsb +: 4];
        r.mem_wmask = hdr[HdrWmaskLsb +: 4];
        return r;
    endfunction

endpackage

// File: rtl/ibex_rvfi_replay_fifo.sv
// rtl/ibex_rvfi_replay_fifo.sv - synchronous FIFO of complete replay records
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset (empties the FIFO)
//   push_i, wdata_i   write request and record; ignored when full unless a pop frees a slot
//   pop_i, rdata_o    read request and head record (valid while !empty_o)
//   full_o, empty_o   occupancy flags, from registered count only
module ibex_rvfi_replay_fifo
    import ibex_rvfi_replay_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  rvfi_rec_t wdata_i,
    input  logic      pop_i,
    output rvfi_rec_t rdata_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    rvfi_rec_t         mem_q [Depth];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   cnt_q;
    logic              do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A simultaneous pop frees the slot this push lands in.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Storage needs no reset: contents are only observed through valid entries.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ibex_rvfi_replay.sv
// rtl/ibex_rvfi_replay.sv - replays 10-word retirement records from a word stream onto an RVFI port
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   s_valid_i/s_ready_o/s_data_i  record word stream (header, insn, pc_rdata, pc_wdata,
//                             rs1_rdata, rs2_rdata, rd_wdata, mem_addr, mem_rdata, mem_wdata)
//   replay_en_i               allows buffered records to be emitted
//   err_magic_o               one-cycle pulse after a header with a bad magic is accepted
//   busy_o                    a record is partly received or records are buffered
//   rvfi_*                    registered RVFI retirement port, at most one record per cycle
module ibex_rvfi_replay
    import ibex_rvfi_replay_pkg::*;
#(
    parameter int unsigned FifoDepth = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    input  logic [31:0] s_data_i,
    input  logic        replay_en_i,
    output logic        err_magic_o,
    output logic        busy_o,
    output logic        rvfi_valid,
    output logic [63:0] rvfi_order,
    output logic [31:0] rvfi_insn,
    output logic        rvfi_trap,
    output logic        rvfi_halt,
    output logic        rvfi_intr,
    output logic [1:0]  rvfi_mode,
    output logic [1:0]  rvfi_ixl,
    output logic [4:0]  rvfi_rs1_addr,
    output logic [4:0]  rvfi_rs2_addr,
    output logic [4:0]  rvfi_rs3_addr,
    output logic [31:0] rvfi_rs1_rdata,
    output logic [31:0] rvfi_rs2_rdata,
    output logic [31:0] rvfi_rs3_rdata,
    output logic [4:0]  rvfi_rd_addr,
    output logic [31:0] rvfi_rd_wdata,
    output logic [31:0] rvfi_pc_rdata,
    output logic [31:0] rvfi_pc_wdata,
    output logic [31:0] rvfi_mem_addr,
    output logic [3:0]  rvfi_mem_rmask,
    output logic [3:0]  rvfi_mem_wmask,
    output logic [31:0] rvfi_mem_rdata,
    output logic [31:0] rvfi_mem_wdata
);

    localparam logic [3:0] LastWord = 4'(RecWords - 1);

    logic [3:0]  word_cnt_q, word_cnt_d;
    logic        bad_q, bad_d;
    rvfi_rec_t   rec_q, rec_d;
    logic        err_magic_q, err_magic_d;
    logic [63:0] order_q, order_d;
    logic        out_valid_q, out_valid_d;
    logic [63:0] out_order_q, out_order_d;
    rvfi_rec_t   out_rec_q, out_rec_d;

    logic        accept, last_word, push, pop;
    logic        fifo_full, fifo_empty;
    rvfi_rec_t   fifo_rdata;

    assign last_word = (word_cnt_q == LastWord);
    // Registered-state only: a pop in the same cycle does not open the input.
    assign s_ready_o = !(last_word && fifo_full);
    assign accept    = s_valid_i && s_ready_o;
    assign push      = accept && last_word && !bad_q;
    assign pop       = replay_en_i && !fifo_empty;
    assign busy_o    = (word_cnt_q != '0) || !fifo_empty;

    always_comb begin
        word_cnt_d  = word_cnt_q;
        bad_d       = bad_q;
        rec_d       = rec_q;
        err_magic_d = 1'b0;
        if (accept) begin
            word_cnt_d = last_word ? '0 : word_cnt_q + 1'b1;
            case (word_cnt_q)
                4'd0: begin
                    rec_d       = hdr_decode(rec_q, s_data_i);
                    bad_d       = (s_data_i[HdrMagicLsb +: 4] != RecMagic);
                    err_magic_d = bad_d;
                end
                4'd1:    rec_d.insn      = s_data_i;
                4'd2:    rec_d.pc_rdata  = s_data_i;
                4'd3:    rec_d.pc_wdata  = s_data_i;
                4'd4:    rec_d.rs1_rdata = s_data_i;
                4'd5:    rec_d.rs2_rdata = s_data_i;
                4'd6:    rec_d.rd_wdata  = s_data_i;
                4'd7:    rec_d.mem_addr  = s_data_i;
                4'd8:    rec_d.mem_rdata = s_data_i;
                default: rec_d.mem_wdata = s_data_i;
            endcase
        end
    end

    always_comb begin
        order_d     = order_q;
        out_valid_d = pop;
        out_order_d = out_order_q;
        out_rec_d   = out_rec_q;
        if (pop) begin
            out_order_d = order_q;
            out_rec_d   = fifo_rdata;
            order_d     = order_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_cnt_q  <= '0;
            bad_q       <= 1'b0;
            rec_q       <= '0;
            err_magic_q <= 1'b0;
            order_q     <= '0;
            out_valid_q <= 1'b0;
            out_order_q <= '0;
            out_rec_q   <= '0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            bad_q       <= bad_d;
            rec_q       <= rec_d;
            err_magic_q <= err_magic_d;
            order_q     <= order_d;
            out_valid_q <= out_valid_d;
            out_order_q <= out_order_d;
            out_rec_q   <= out_rec_d;
        end
    end

    // rec_d carries the final word, so the complete record is written at the word-9 edge.
    ibex_rvfi_replay_fifo #(
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i (rec_d),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign err_magic_o    = err_magic_q;
    assign rvfi_valid     = out_valid_q;
    assign rvfi_order     = out_order_q;
    assign rvfi_insn      = out_rec_q.insn;
    assign rvfi_trap      = out_rec_q.trap;
    assign rvfi_halt      = out_rec_q.halt;
    assign rvfi_intr      = out_rec_q.intr;
    assign rvfi_mode      = out_rec_q.mode;
    assign rvfi_ixl       = 2'b01;
    assign rvfi_rs1_addr  = out_rec_q.rs1_addr;
    assign rvfi_rs2_addr  = out_rec_q.rs2_addr;
    assign rvfi_rs3_addr  = 5'd0;
    assign rvfi_rs1_rdata = out_rec_q.rs1_rdata;
    assign rvfi_rs2_rdata = out_rec_q.rs2_rdata;
    assign rvfi_rs3_rdata = 32'd0;
    assign rvfi_rd_addr   = out_rec_q.rd_addr;
    assign rvfi_rd_wdata  = out_rec_q.rd_wdata;
    assign rvfi_pc_rdata  = out_rec_q.pc_rdata;
    assign rvfi_pc_wdata  = out_rec_q.pc_wdata;
    assign rvfi_mem_addr  = out_rec_q.mem_addr;
    assign rvfi_mem_rmask = out_rec_q.mem_rmask;
    assign rvfi_mem_wmask = out_rec_q.mem_wmask;
    assign rvfi_mem_rdata = out_rec_q.mem_rdata;
    assign rvfi_mem_wdata = out_rec_q.mem_wdata;

endmodule

// File: tb/tb_ibex_rvfi_replay.sv
// tb/tb_ibex_rvfi_replay.sv - self-checking bench for ibex_rvfi_replay
module tb_ibex_rvfi_replay;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid_i = 1'b0;
    logic [31:0] s_data_i = '0;
    logic        replay_en_i = 1'b0;
    logic        s_ready_o, err_magic_o, busy_o;
    logic        rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr;
    logic [63:0] rvfi_order;
    logic [1:0]  rvfi_mode, rvfi_ixl;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr, rvfi_rd_addr;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
    logic [31:0] rvfi_insn, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata, rvfi_rd_wdata;
    logic [31:0] rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;

    ibex_rvfi_replay #(.FifoDepth(2)) dut (
        .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
        .replay_en_i(replay_en_i), .err_magic_o(err_magic_o), .busy_o(busy_o),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr), .rvfi_mode(rvfi_mode),
        .rvfi_ixl(rvfi_ixl), .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rs3_addr(rvfi_rs3_addr), .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rs3_rdata(rvfi_rs3_rdata), .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_mem_addr(rvfi_mem_addr),
        .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata)
    );

    always #5 clk = ~clk;

    // fields = {trap, halt, intr, mode, rd, rs1, rs2, rmask, wmask}
    typedef struct {
        logic [31:0] hdr;
        bit          good;
        logic [27:0] fields;
    } vec_t;

    typedef struct {
        logic [9:0][31:0] words;
        logic [27:0]      fields;
        logic [63:0]      order;
    } exp_t;

    vec_t  tbl [4];
    exp_t  sb [$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    valid_cnt = 0;
    int    err_cnt = 0;
    int    last_valid_cyc = 0;
    int    w9_cyc = 0;
    bit    stall_seen = 0;
    logic [63:0] exp_order = '0;
    logic [31:0] last_exp_insn = '0;

    function automatic vec_t mk(logic [31:0] hdr, bit good, bit trap, bit halt, bit intr,
                                logic [1:0] mode, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                logic [3:0] rm, logic [3:0] wm);
        vec_t v;
        v.hdr    = hdr;
        v.good   = good;
        v.fields = {trap, halt, intr, mode, rd, rs1, rs2, rm, wm};
        return v;
    endfunction

    task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every rvfi_valid retires the oldest expected record.
    always @(negedge clk) begin
        exp_t e;
        if (err_magic_o) err_cnt++;
        if (!rst && rvfi_valid) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=1 required=0 order=%0d", rvfi_order);
            end else begin
                e = sb.pop_front();
                last_exp_insn = e.words[1];
                chk("rvfi_order", 288'(rvfi_order), 288'(e.order));
                chk("hdr_fields", 288'({rvfi_trap, rvfi_halt, rvfi_intr, rvfi_mode, rvfi_rd_addr,
                                        rvfi_rs1_addr, rvfi_rs2_addr, rvfi_mem_rmask, rvfi_mem_wmask}),
                    288'(e.fields));
                chk("payload", {rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_rdata, rvfi_rs2_rdata,
                                rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata},
                    {e.words[1], e.words[2], e.words[3], e.words[4], e.words[5],
                     e.words[6], e.words[7], e.words[8], e.words[9]});
                chk("constants", 288'({rvfi_ixl, rvfi_rs3_addr, rvfi_rs3_rdata}), 288'({2'b01, 5'd0, 32'd0}));
            end
        end
    end

    task automatic send_word(input logic [31:0] w, output bit ok);
        int  n;
        bit  rdy;
        n = 0;
        s_valid_i = 1'b1;
        s_data_i  = w;
        do begin
            @(negedge clk);
            rdy = s_ready_o;
            if (!rdy) stall_seen = 1;
            @(posedge clk);
            n++;
        end while (!rdy && n < 400);
        #1;
        s_valid_i = 1'b0;
        ok = rdy;
    endtask

    task automatic send_record(input int vi, input int nwords);
        exp_t e;
        bit   ok;
        e.words[0] = tbl[vi].hdr;
        for (int i = 1; i < 10; i++) e.words[i] = $urandom;
        e.fields = tbl[vi].fields;
        e.order  = '0;
        for (int i = 0; i < nwords; i++) begin
            if (i == 9 && tbl[vi].good) begin
                e.order = exp_order;
                exp_order++;
                sb.push_back(e);
            end
            send_word(e.words[i], ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL word_accept_timeout actual=0 required=1 word=%0d", i);
            end
            if (i == 9) w9_cyc = cyc;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy_o) && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_scoreboard", 288'(sb.size()), 288'(0));
    endtask

    initial begin
        int v0, e0, n;
        tbl[0] = mk(32'hA0A4_2034, 1, 0, 0, 0, 2'd1, 5'h09, 5'h01, 5'h00, 4'h3, 4'h4);
        tbl[1] = mk(32'hAB7C_5EF1, 1, 1, 0, 1, 2'd2, 5'h1F, 5'h02, 5'h1E, 4'hF, 4'h1);
        tbl[2] = mk(32'h5000_0000, 0, 0, 0, 0, 2'd0, 5'h00, 5'h00, 5'h00, 4'h0, 4'h0);
        tbl[3] = mk(32'hA583_E10F, 1, 0, 1, 0, 2'd3, 5'h00, 5'h1F, 5'h01, 4'h0, 4'hF);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 288'({s_ready_o, busy_o, rvfi_valid, err_magic_o, rvfi_ixl, rvfi_order, rvfi_insn}),
            288'({1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 64'd0, 32'd0}));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single record: latency and hold
        replay_en_i = 1'b1;
        send_record(0, 10);
        wait_drain();
        chk("single_valid_count", 288'(valid_cnt), 288'(1));
        chk("single_latency", 288'(last_valid_cyc), 288'(w9_cyc + 1));
        chk("hold_fields", 288'({rvfi_valid, rvfi_insn, rvfi_order}), 288'({1'b0, last_exp_insn, 64'd0}));

        // Table: back-to-back records including one with a bad magic
        v0 = valid_cnt;
        e0 = err_cnt;
        stall_seen = 0;
        for (int i = 0; i < 4; i++) send_record(i, 10);
        wait_drain();
        chk("b2b_valid_count", 288'(valid_cnt - v0), 288'(3));
        chk("b2b_no_stall", 288'(stall_seen), 288'(0));
        chk("bad_magic_pulse_cycles", 288'(err_cnt - e0), 288'(1));

        // Back-pressure with replay disabled, then release
        replay_en_i = 1'b0;
        v0 = valid_cnt;
        stall_seen = 0;
        send_record(0, 10);
        send_record(1, 10);
        fork
            send_record(3, 10);
            begin
                n = 0;
                while (!stall_seen && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_stall_seen", 288'(stall_seen), 288'(1));
                repeat (3) @(negedge clk);
                chk("bp_ready_low", 288'({s_ready_o, busy_o}), 288'({1'b0, 1'b1}));
                chk("bp_no_output", 288'(valid_cnt - v0), 288'(0));
                @(posedge clk);
                #1;
                replay_en_i = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk("bp_ready_rises", 288'(s_ready_o), 288'(1));
            end
        join
        wait_drain();
        chk("bp_valid_count", 288'(valid_cnt - v0), 288'(3));

        // Reset in the middle of a record
        send_record(1, 5);
        rst = 1'b1;
        #2;
        chk("midrst_outputs", 288'({s_ready_o, busy_o, rvfi_valid, rvfi_order}), 288'({1'b1, 1'b0, 1'b0, 64'd0}));
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_order = '0;
        v0 = valid_cnt;
        send_record(3, 10);
        wait_drain();
        chk("midrst_valid_count", 288'(valid_cnt - v0), 288'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
